// File: rtl/uart_tx.sv
// UART transmitter: accepts one payload word per valid/ready handshake and
// shifts it out LSB first as an asynchronous frame (start, data, optional
// parity, one or two stop bits). Bit timing comes from a per-bit baud
// counter running on clk_i. The serial line is driven from a flop so it
// never glitches while the state machine changes state.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       STOP_LAST = (STOP_BITS == 2);
  localparam logic       PAR_INIT  = (PARITY == 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state_q,   state_d;
  logic [BAUD_W-1:0]    baud_q,    baud_d;
  logic [2:0]           bitIdx_q,  bitIdx_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic                 parity_q,  parity_d;
  logic                 stopCnt_q, stopCnt_d;
  logic                 tx_q,      tx_d;
  logic                 busy_q,    busy_d;
  logic                 baudLast;

  assign baudLast = (baud_q == BAUD_LAST);
  assign ready_o  = (state_q == S_IDLE);
  assign tx_o     = tx_q;
  assign busy_o   = busy_q;

  // Next-state logic; the line level is derived from the next state so the tx flop leads with the new bit.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    stopCnt_d = stopCnt_q;

    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          state_d   = S_START;
          baud_d    = '0;
          bitIdx_d  = 3'd0;
          shift_d   = data_i;
          parity_d  = PAR_INIT;
          stopCnt_d = 1'b0;
        end
      end
      S_START: begin
        if (baudLast) begin
          state_d  = S_DATA;
          baud_d   = '0;
          bitIdx_d = 3'd0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baudLast) begin
          baud_d   = '0;
          parity_d = parity_q ^ shift_q[0];
          shift_d  = shift_q >> 1;
          bitIdx_d = bitIdx_q + 3'd1;
          if (bitIdx_q == LAST_BIT) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_PARITY: begin
        if (baudLast) begin
          state_d   = S_STOP;
          baud_d    = '0;
          stopCnt_d = 1'b0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baudLast) begin
          baud_d = '0;
          if (stopCnt_q == STOP_LAST) begin
            state_d = S_IDLE;
          end else begin
            stopCnt_d = stopCnt_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, counters, shift register and the registered line/busy outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bitIdx_q  <= 3'd0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      stopCnt_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      stopCnt_q <= stopCnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

endmodule
